// File: rtl/pulse_period_meter_if.sv
// pulse_period_meter_if: result handshake between the period meter and its consumer.
interface pulse_period_meter_if #(parameter int N = 8);
    logic [N-1:0] period;
    logic         valid;
    logic         ready;
    logic         overflow;
    logic         missed;

    modport master (output period, output valid, output overflow, output missed, input ready);
    modport slave  (input period, input valid, input overflow, input missed, output ready);
endinterface

// File: rtl/pulse_period_meter.sv
// pulse_period_meter: measures rising-edge spacing of an asynchronous pulse train,
// reporting spacing-1 so a generator programmed with ticks=T reads back T.
module pulse_period_meter #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    pulse_in,
    pulse_period_meter_if.master    m
);
    typedef enum logic {IDLE, ARMED} state_t;

    state_t                 r_state, w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [N-1:0]           r_count, r_period;
    logic                   r_valid, r_overflow, r_missed;
    logic                   w_edge, w_capture, w_sat;

    assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

    // Synchroniser and edge history run even while ena is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pulse_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (ena && r_state == IDLE && w_edge) w_next = ARMED;
        if (ena && r_state == ARMED && !w_edge && r_count == '1) w_next = IDLE;
    end

    always_comb begin
        w_capture = ena && r_state == ARMED && w_edge;
        w_sat     = ena && r_state == ARMED && !w_edge && r_count == '1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count    <= '0;
            r_period   <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_missed   <= 1'b0;
        end else begin
            if (ena) r_count <= (r_state == IDLE || w_capture || w_sat) ? '0 : r_count + 1'b1;
            if (w_capture) r_period <= r_count;
            r_valid    <= w_capture | (r_valid & ~m.ready);
            r_missed   <= r_missed | (w_capture & r_valid & ~m.ready);
            r_overflow <= w_sat ? 1'b1 : w_capture ? 1'b0 : r_overflow;
        end
    end

    assign m.period   = r_period;
    assign m.valid    = r_valid;
    assign m.overflow = r_overflow;
    assign m.missed   = r_missed;
endmodule

// File: tb/tb_pulse_period_meter.sv
// tb_pulse_period_meter: directed and random pulse trains checked every cycle
// against a spacing-based model of the meter.
module tb_pulse_period_meter;
    localparam int N = 8;
    localparam int S = 2;

    logic clk = 0;
    logic rst;
    logic ena;
    logic pulse_in;
    int   checks = 0;
    int   errors = 0;

    pulse_period_meter_if #(.N(N)) bus();

    pulse_period_meter #(.N(N), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .ena(ena), .pulse_in(pulse_in), .m(bus)
    );

    always #5 clk = ~clk;

    // Model: samples of pulse_in, and ena-cycles elapsed since the arming edge
    bit hist [0:S] = '{default: 0};
    bit armed = 0;
    int since = 0;
    int m_period = 0;
    bit m_valid = 0, m_ovf = 0, m_missed = 0;

    always @(posedge clk or negedge rst) begin
        bit e, cap;
        if (!rst) begin
            for (int i = 0; i <= S; i++) hist[i] = 0;
            armed = 0; since = 0; m_period = 0; m_valid = 0; m_ovf = 0; m_missed = 0;
        end else begin
            e   = hist[S-1] && !hist[S];
            cap = 0;
            if (ena && armed) begin
                since++;
                if (e) cap = 1;
                else if (since == 2**N) begin armed = 0; m_ovf = 1; end
            end else if (ena && e) begin
                armed = 1;
                since = 0;
            end
            if (cap) begin
                if (m_valid && !bus.ready) m_missed = 1;
                m_period = since - 1;
                m_valid  = 1;
                m_ovf    = 0;
                since    = 0;
            end else if (m_valid && bus.ready) m_valid = 0;
            for (int i = S; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = pulse_in;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("period", int'(bus.period), m_period);
            chk("valid", int'(bus.valid), int'(m_valid));
            chk("overflow", int'(bus.overflow), int'(m_ovf));
            chk("missed", int'(bus.missed), int'(m_missed));
        end
    end

    task automatic step(input bit p);
        pulse_in = p;
        @(negedge clk);
    endtask

    task automatic pulse_after(input int gap);
        repeat (gap - 1) step(0);
        step(1);
    endtask

    initial begin
        rst = 0; ena = 1; pulse_in = 0; bus.ready = 1;
        repeat (3) @(negedge clk);
        chk("rst_period", int'(bus.period), 0);
        chk("rst_valid", int'(bus.valid), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_missed", int'(bus.missed), 0);
        rst = 1;
        // Regular train, 6 apart
        repeat (4) pulse_after(6);
        repeat (4) step(0);
        chk("t1_period", int'(bus.period), 5);
        // Overwrite without acceptance
        bus.ready = 0;
        pulse_after(6);
        pulse_after(10);
        repeat (4) step(0);
        chk("t2_period", int'(bus.period), 9);
        chk("t2_valid", int'(bus.valid), 1);
        chk("t2_missed", int'(bus.missed), 1);
        bus.ready = 1;
        step(0);
        chk("t2_accept", int'(bus.valid), 0);
        // Saturation then re-arm
        pulse_after(5);
        repeat (300) step(0);
        chk("t3_overflow", int'(bus.overflow), 1);
        pulse_after(10);
        pulse_after(10);
        repeat (4) step(0);
        chk("t3_period", int'(bus.period), 9);
        chk("t3_overflow_clr", int'(bus.overflow), 0);
        // ena gap inside a measurement
        pulse_after(8);
        repeat (2) step(0);
        ena = 0; repeat (3) step(0);
        ena = 1; repeat (2) step(0);
        step(1);
        repeat (4) step(0);
        chk("t4_period", int'(bus.period), 4);
        ena = 0;
        step(1);
        repeat (5) step(0);
        chk("t4_dropped", int'(bus.valid), 0);
        ena = 1;
        // Async reset mid-count
        pulse_after(6);
        repeat (2) step(0);
        #2 rst = 0;
        #1;
        chk("t5_period", int'(bus.period), 0);
        chk("t5_valid", int'(bus.valid), 0);
        chk("t5_overflow", int'(bus.overflow), 0);
        chk("t5_missed", int'(bus.missed), 0);
        @(negedge clk);
        repeat (2) step(0);
        rst = 1;
        pulse_after(4);
        pulse_after(4);
        repeat (4) step(0);
        chk("t5_period_after", int'(bus.period), 3);
        // Fastest train
        repeat (10) begin step(1); step(0); end
        repeat (4) step(0);
        chk("t6_period", int'(bus.period), 1);
        // Held-high level from reset arms only
        rst = 0;
        step(0);
        rst = 1;
        repeat (20) step(1);
        chk("t6_held_valid", int'(bus.valid), 0);
        chk("t6_held_period", int'(bus.period), 0);
        repeat (3) step(0);
        // Random trains, enables and back-pressure
        repeat (600) begin
            ena       = ($urandom_range(0, 9) != 0);
            bus.ready = $urandom_range(0, 3) != 0;
            step($urandom_range(0, 4) == 0);
        end
        repeat (2) begin
            pulse_after($urandom_range(200, 280));
        end
        repeat (5) step(0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
